// File: rtl/snn_vote_classifier.sv
// snn_vote_classifier: per-image spike counting, winner search, and neuron label learning/readout.
// Test mode adds a tally vote and relabels the winner; classify mode returns the winner's label.
module snn_vote_classifier #(
    parameter int         N        = 8,
    parameter int         C        = 10,
    parameter int         CW       = 8,
    parameter int         TW       = 12,
    parameter logic [7:0] NO_LABEL = 8'hFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   i_train_test_classify,
    input  logic         i_start_img,
    input  logic         i_coring,
    input  logic         i_tu_incre,
    input  logic [N-1:0] i_ops,
    input  logic [7:0]   i_test_label,
    input  logic         i_deciding,
    output logic         o_valid_deciding,
    output logic [7:0]   o_image_label,
    output logic         o_busy
);
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = $clog2(C);
    typedef enum logic [2:0] {IDLE, SCAN, UPDATE, ASSIGN, DONE} state_t;
    state_t        r_state;
    logic [CW-1:0] r_cnt [N];
    logic [TW-1:0] r_tally [N][C];
    logic [7:0]    r_label [N];
    logic          r_pend;
    logic [1:0]    r_mode;
    logic [7:0]    r_tl;
    logic [NW-1:0] r_idx, r_win;
    logic [CW-1:0] r_max;
    logic [KW-1:0] r_cls;
    logic          r_wb;
    logic [TW-1:0] r_best;
    logic [7:0]    r_best_cls;
    logic          w_clear, w_count, w_tally_ok;
    logic [TW-1:0] w_row_val, w_hit_val;

    assign o_busy     = r_state != IDLE;
    // A start_img seen while busy is deferred to the DONE->IDLE edge.
    assign w_clear    = (r_state == IDLE && i_start_img) || (r_state == DONE && (r_pend || i_start_img));
    assign w_count    = i_coring && i_tu_incre && !r_pend;
    assign w_tally_ok = r_max != '0 && r_tl < 8'(C);
    assign w_row_val  = r_tally[r_win][r_cls];
    assign w_hit_val  = r_tally[r_win][r_tl[KW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else begin
            if (r_state == DONE) r_pend <= 1'b0;
            else if (i_start_img && r_state != IDLE) r_pend <= 1'b1;
            for (int i = 0; i < N; i++)
                if (w_clear) r_cnt[i] <= '0;
                else if (w_count && i_ops[i] && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            o_valid_deciding <= 1'b0;
            o_image_label    <= NO_LABEL;
            r_mode           <= '0;
            r_tl             <= '0;
            r_idx            <= '0;
            r_win            <= '0;
            r_max            <= '0;
            r_cls            <= '0;
            r_wb             <= 1'b0;
            r_best           <= '0;
            r_best_cls       <= NO_LABEL;
            for (int i = 0; i < N; i++) begin
                r_label[i] <= NO_LABEL;
                for (int j = 0; j < C; j++) r_tally[i][j] <= '0;
            end
        end else begin
            o_valid_deciding <= 1'b0;
            case (r_state)
                IDLE: if (i_deciding) begin
                    r_mode  <= i_train_test_classify;
                    r_tl    <= i_test_label;
                    r_max   <= '0;
                    r_win   <= '0;
                    r_idx   <= '0;
                    r_state <= SCAN;
                end
                SCAN: begin
                    if (r_cnt[r_idx] > r_max) begin
                        r_max <= r_cnt[r_idx];
                        r_win <= r_idx;
                    end
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == NW'(N - 1)) r_state <= UPDATE;
                end
                UPDATE: begin
                    r_cls      <= '0;
                    r_wb       <= 1'b0;
                    r_best     <= '0;
                    r_best_cls <= NO_LABEL;
                    if (r_mode == 2'b10) begin
                        o_image_label    <= r_max != '0 ? r_label[r_win] : NO_LABEL;
                        o_valid_deciding <= 1'b1;
                        r_state          <= DONE;
                    end else if (r_mode == 2'b01) begin
                        o_image_label <= r_tl;
                        if (w_tally_ok) begin
                            if (w_hit_val != '1) r_tally[r_win][r_tl[KW-1:0]] <= w_hit_val + 1'b1;
                            r_state <= ASSIGN;
                        end else begin
                            o_valid_deciding <= 1'b1;
                            r_state          <= DONE;
                        end
                    end else begin
                        o_image_label    <= NO_LABEL;
                        o_valid_deciding <= 1'b1;
                        r_state          <= DONE;
                    end
                end
                // C compare cycles over the winner's row, then one write-back cycle.
                ASSIGN: begin
                    if (r_wb) begin
                        r_label[r_win]   <= r_best_cls;
                        o_valid_deciding <= 1'b1;
                        r_state          <= DONE;
                    end else begin
                        if (w_row_val > r_best) begin
                            r_best     <= w_row_val;
                            r_best_cls <= 8'(r_cls);
                        end
                        r_cls <= r_cls + 1'b1;
                        if (r_cls == KW'(C - 1)) r_wb <= 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
